// File: rtl/fft_unload.sv
// Unloads a parallel 32-bin FFT frame and streams it out one complex word per handshake.
// Optional output order: define FFT_UNLOAD_BITREV_EN to emit bins in bit-reversed order.
//
// state  | meaning
// IDLE   | waiting for a frame, load_ready high, nothing on the output
// STREAM | frame held in the bank, presenting sequence s until out_ready takes it
module fft_unload #(
    parameter bit IDLE_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] d0,
    input  logic [63:0] d1,
    input  logic [63:0] d2,
    input  logic [63:0] d3,
    input  logic [63:0] d4,
    input  logic [63:0] d5,
    input  logic [63:0] d6,
    input  logic [63:0] d7,
    input  logic [63:0] d8,
    input  logic [63:0] d9,
    input  logic [63:0] d10,
    input  logic [63:0] d11,
    input  logic [63:0] d12,
    input  logic [63:0] d13,
    input  logic [63:0] d14,
    input  logic [63:0] d15,
    input  logic [63:0] d16,
    input  logic [63:0] d17,
    input  logic [63:0] d18,
    input  logic [63:0] d19,
    input  logic [63:0] d20,
    input  logic [63:0] d21,
    input  logic [63:0] d22,
    input  logic [63:0] d23,
    input  logic [63:0] d24,
    input  logic [63:0] d25,
    input  logic [63:0] d26,
    input  logic [63:0] d27,
    input  logic [63:0] d28,
    input  logic [63:0] d29,
    input  logic [63:0] d30,
    input  logic [63:0] d31,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_index,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] din [32];
    logic [63:0] bank [32];
    logic [63:0] last_data;
    logic [4:0]  seq;
    logic [4:0]  bin;
    logic        load_fire;
    logic        xfer_fire;

    assign din[0]  = d0;
    assign din[1]  = d1;
    assign din[2]  = d2;
    assign din[3]  = d3;
    assign din[4]  = d4;
    assign din[5]  = d5;
    assign din[6]  = d6;
    assign din[7]  = d7;
    assign din[8]  = d8;
    assign din[9]  = d9;
    assign din[10] = d10;
    assign din[11] = d11;
    assign din[12] = d12;
    assign din[13] = d13;
    assign din[14] = d14;
    assign din[15] = d15;
    assign din[16] = d16;
    assign din[17] = d17;
    assign din[18] = d18;
    assign din[19] = d19;
    assign din[20] = d20;
    assign din[21] = d21;
    assign din[22] = d22;
    assign din[23] = d23;
    assign din[24] = d24;
    assign din[25] = d25;
    assign din[26] = d26;
    assign din[27] = d27;
    assign din[28] = d28;
    assign din[29] = d29;
    assign din[30] = d30;
    assign din[31] = d31;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (load_valid) state_nxt = STREAM;
            STREAM: if (out_ready && (seq == 5'd31)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE:   load_ready = 1'b1;
            STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: load_ready = 1'b0;
        endcase
    end

    assign load_fire = load_valid & load_ready;
    assign xfer_fire = out_valid & out_ready;

    // The final transfer rolls seq back to 0, which is also the idle value.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq <= 5'd0;
        end else if (load_fire) begin
            seq <= 5'd0;
        end else if (xfer_fire) begin
            seq <= seq + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire && !rst) begin
            for (int i = 0; i < 32; i++) begin
                bank[i] <= din[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_data <= 64'h0;
        end else if (xfer_fire) begin
            last_data <= bank[bin];
        end
    end

`ifdef FFT_UNLOAD_BITREV_EN
    assign bin = {seq[0], seq[1], seq[2], seq[3], seq[4]};
`else
    assign bin = seq;
`endif

    assign out_index = bin;
    assign out_last  = out_valid && (seq == 5'd31);

    always_comb begin
        if (out_valid) begin
            out_data = bank[bin];
        end else if (IDLE_ZERO) begin
            out_data = 64'h0;
        end else begin
            out_data = last_data;
        end
    end

endmodule

// File: tb/tb_fft_unload.sv
// Directed/randomized bench for fft_unload: expected beat order and words come from a
// per-frame reference list built from the captured input frame.
module tb_fft_unload;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] d [32];
    logic        load_valid;
    logic        load_ready;
    logic [63:0] out_data;
    logic [4:0]  out_index;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int c0;

    logic [63:0] fr  [32];
    logic [63:0] fr2 [32];
    logic [63:0] exp_word [32];
    logic [4:0]  exp_idx  [32];

    always #5 clk = ~clk;

    fft_unload dut (
        .clk(clk), .rst(rst),
        .d0(d[0]),   .d1(d[1]),   .d2(d[2]),   .d3(d[3]),
        .d4(d[4]),   .d5(d[5]),   .d6(d[6]),   .d7(d[7]),
        .d8(d[8]),   .d9(d[9]),   .d10(d[10]), .d11(d[11]),
        .d12(d[12]), .d13(d[13]), .d14(d[14]), .d15(d[15]),
        .d16(d[16]), .d17(d[17]), .d18(d[18]), .d19(d[19]),
        .d20(d[20]), .d21(d[21]), .d22(d[22]), .d23(d[23]),
        .d24(d[24]), .d25(d[25]), .d26(d[26]), .d27(d[27]),
        .d28(d[28]), .d29(d[29]), .d30(d[30]), .d31(d[31]),
        .load_valid(load_valid), .load_ready(load_ready),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    function automatic int bin_of(input int s);
`ifdef FFT_UNLOAD_BITREV_EN
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (((s >> b) & 1) != 0) r += (1 << (4 - b));
        end
        return r;
`else
        return s;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic build_model;
        for (int s = 0; s < 32; s++) begin
            exp_idx[s]  = 5'(bin_of(s));
            exp_word[s] = fr[bin_of(s)];
        end
    endtask

    task automatic rand_frame;
        for (int k = 0; k < 32; k++) fr[k] = {$urandom, $urandom};
    endtask

    task automatic drive_frame;
        for (int k = 0; k < 32; k++) d[k] = fr[k];
    endtask

    task automatic load_frame;
        build_model();
        drive_frame();
        load_valid = 1'b1;
        chk("load_ready_idle", load_ready, 1);
        chk("valid_before_load", out_valid, 0);
        step();
        load_valid = 1'b0;
        chk("latency_valid", out_valid, 1);
        chk("first_index", out_index, exp_idx[0]);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
    task automatic stream(input int mode, input bit glitch, input int stop_after);
        int beats = 0;
        int budget = 0;
        int ph = 0;
        bit rdy;
        while (beats < stop_after && budget < 400) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_index", out_index, exp_idx[beats]);
            chk("beat_data", out_data, exp_word[beats]);
            chk("beat_last", out_last, (beats == 31));
            chk("beat_load_ready", load_ready, 0);
            chk("beat_busy", busy, 1);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((ph % 3) == 0);
                default: rdy = 1'($urandom % 2);
            endcase
            ph++;
            out_ready = rdy;
            if (glitch) begin
                load_valid = 1'($urandom % 2);
                for (int k = 0; k < 32; k++) d[k] = {$urandom, $urandom};
            end
            step();
            budget++;
            if (rdy) beats++;
        end
        if (glitch) load_valid = 1'b0;
        chk("stream_beats", beats, stop_after);
    endtask

    task automatic idle_checks;
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_load_ready", load_ready, 1);
        chk("idle_data", out_data, 64'h0);
        chk("idle_last", out_last, 0);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        out_ready  = 1'b0;
        for (int k = 0; k < 32; k++) d[k] = 64'h0;
        step();
        load_valid = 1'b1;   // reset must win over a coincident load
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 64'h0);
        chk("rst_busy", busy, 0);
        chk("rst_index", out_index, 0);
        chk("rst_last", out_last, 0);
        chk("rst_load_ready", load_ready, 1);
        rst        = 1'b0;
        load_valid = 1'b0;
        step();
        idle_checks();

        // ramp frame, full-rate drain
        for (int k = 0; k < 32; k++) fr[k] = {32'h3F800000, 32'(k)};
        load_frame();
        stream(0, 1'b0, 32);
        idle_checks();

        // 1,0,0 stall pattern
        rand_frame();
        load_frame();
        stream(1, 1'b0, 32);
        idle_checks();

        // random stalls with load attempts and changing d during the stream
        rand_frame();
        load_frame();
        stream(2, 1'b1, 32);
        idle_checks();

        // abort after beat 10, reset also coincides with a transfer
        rand_frame();
        load_frame();
        stream(0, 1'b0, 11);
        rst = 1'b1;
        step();
        chk("abort_valid", out_valid, 0);
        chk("abort_data", out_data, 64'h0);
        chk("abort_busy", busy, 0);
        chk("abort_index", out_index, 0);
        rst       = 1'b0;
        out_ready = 1'b0;
        step();
        idle_checks();
        rand_frame();
        load_frame();
        stream(0, 1'b0, 32);
        idle_checks();

        // back-to-back frames with load_valid held high
        rand_frame();
        for (int k = 0; k < 32; k++) fr2[k] = {$urandom, $urandom};
        build_model();
        drive_frame();
        load_valid = 1'b1;
        step();
        c0 = cyc;
        for (int k = 0; k < 32; k++) d[k] = fr2[k];
        stream(0, 1'b0, 32);
        chk("b2b_load_ready", load_ready, 1);
        step();
        chk("b2b_period", cyc - c0, 33);
        load_valid = 1'b0;
        for (int k = 0; k < 32; k++) fr[k] = fr2[k];
        build_model();
        chk("b2b_valid", out_valid, 1);
        stream(0, 1'b0, 32);
        idle_checks();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
